// File: rtl/ws2812_pattern_gen.sv
// ws2812_pattern_gen
//   Frame-based pattern source for the ws2812 core. Once per frame period it
//   streams one colour per LED (LEDs 0..NUM_LEDS-1) to the core's write port.
//   Supports four modes (SOLID, CHASE, GRADIENT, OFF), a shared intensity
//   level, frame pacing via a wait timer, an enable, and frame status outputs.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   enable       1 = start new frames; 0 = go idle once the current frame ends
//   mode         0 SOLID, 1 CHASE, 2 GRADIENT, 3 OFF
//   level        intensity used for every lit colour component
//   rgb_data     colour for led_num
//   led_num      LED index being written
//   write        1 = rgb_data is valid for led_num this cycle
//   frame_done   one-cycle pulse after the last LED of a frame is written
//   frame_count  completed frames, wraps 255 -> 0

module ws2812_pattern_gen #(
    parameter int NUM_LEDS    = 100,
    parameter int LED_ADDR_W  = 8,
    parameter int FRAME_TICKS = 32768
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [7:0]            level,
    output logic [23:0]           rgb_data,
    output logic [LED_ADDR_W-1:0] led_num,
    output logic                  write,
    output logic                  frame_done,
    output logic [7:0]            frame_count
);

    if ((1 << LED_ADDR_W) < NUM_LEDS) begin : g_bad_addr_w
        $error("ws2812_pattern_gen: LED_ADDR_W too small for NUM_LEDS");
    end
    if (NUM_LEDS < 2) begin : g_bad_num_leds
        $error("ws2812_pattern_gen: NUM_LEDS must be >= 2");
    end
    if (FRAME_TICKS < 1) begin : g_bad_frame_ticks
        $error("ws2812_pattern_gen: FRAME_TICKS must be >= 1");
    end

    localparam int TIMER_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(FRAME_TICKS - 1);
    localparam logic [LED_ADDR_W-1:0] LED_LAST   = LED_ADDR_W'(NUM_LEDS - 1);

    localparam logic [1:0] MODE_SOLID    = 2'd0;
    localparam logic [1:0] MODE_CHASE    = 2'd1;
    localparam logic [1:0] MODE_GRADIENT = 2'd2;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state, state_n;
    logic [TIMER_W-1:0]    timer, timer_n;
    logic [1:0]            frame_mode, frame_mode_n;
    logic [7:0]            frame_level, frame_level_n;
    logic [1:0]            grad, grad_n;
    logic [LED_ADDR_W-1:0] chase_pos, chase_pos_n;
    logic [7:0]            frame_count_n;
    logic [23:0]           rgb_n;
    logic [LED_ADDR_W-1:0] led_n;
    logic                  write_n;
    logic                  done_n;

    function automatic logic [23:0] palette(input logic [1:0] k, input logic [7:0] lv);
        logic [23:0] p;
        case (k)
            2'd0:    p = {lv, 8'h00, 8'h00};
            2'd1:    p = {8'h00, lv, 8'h00};
            2'd2:    p = {8'h00, 8'h00, lv};
            default: p = {lv, lv, lv};
        endcase
        return p;
    endfunction

    // Colour for one LED; g is the running gradient index for that LED.
    function automatic logic [23:0] colour(
        input logic [1:0]            m,
        input logic [7:0]            lv,
        input logic [LED_ADDR_W-1:0] idx,
        input logic [1:0]            g,
        input logic [LED_ADDR_W-1:0] cp,
        input logic [1:0]            fc
    );
        logic [23:0] c;
        case (m)
            MODE_SOLID:    c = palette(fc, lv);
            MODE_CHASE:    c = (idx == cp) ? palette(2'd3, lv) : 24'h0;
            MODE_GRADIENT: c = palette(g, lv);
            default:       c = 24'h0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_WAIT;
            timer       <= '0;
            frame_mode  <= '0;
            frame_level <= '0;
            grad        <= '0;
            chase_pos   <= '0;
            frame_count <= '0;
            rgb_data    <= '0;
            led_num     <= '0;
            write       <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            frame_mode  <= frame_mode_n;
            frame_level <= frame_level_n;
            grad        <= grad_n;
            chase_pos   <= chase_pos_n;
            frame_count <= frame_count_n;
            rgb_data    <= rgb_n;
            led_num     <= led_n;
            write       <= write_n;
            frame_done  <= done_n;
        end
    end

    // Outputs are registered, so each transition computes the values the
    // outputs must carry in the following cycle. The first LED of a frame is
    // coloured straight from the inputs being latched on that same edge.
    always_comb begin
        state_n       = state;
        timer_n       = timer;
        frame_mode_n  = frame_mode;
        frame_level_n = frame_level;
        grad_n        = grad;
        chase_pos_n   = chase_pos;
        frame_count_n = frame_count;
        rgb_n         = 24'h0;
        led_n         = '0;
        write_n       = 1'b0;
        done_n        = 1'b0;

        case (state)
            ST_WAIT: begin
                if (!enable) begin
                    timer_n = '0;
                end else if (timer == TIMER_LAST) begin
                    state_n       = ST_WRITE;
                    timer_n       = '0;
                    frame_mode_n  = mode;
                    frame_level_n = level;
                    grad_n        = frame_count[1:0];
                    write_n       = 1'b1;
                    rgb_n         = colour(mode, level, '0, frame_count[1:0],
                                           chase_pos, frame_count[1:0]);
                end else begin
                    timer_n = timer + TIMER_W'(1);
                end
            end

            ST_WRITE: begin
                if (led_num == LED_LAST) begin
                    state_n       = ST_DONE;
                    done_n        = 1'b1;
                    timer_n       = '0;
                    frame_count_n = frame_count + 8'd1;
                    chase_pos_n   = (chase_pos == LED_LAST) ? '0
                                                            : chase_pos + LED_ADDR_W'(1);
                end else begin
                    write_n = 1'b1;
                    led_n   = led_num + LED_ADDR_W'(1);
                    grad_n  = grad + 2'd1;
                    rgb_n   = colour(frame_mode, frame_level, led_n, grad_n,
                                     chase_pos, frame_count[1:0]);
                end
            end

            ST_DONE: begin
                state_n = ST_WAIT;
                timer_n = '0;
            end

            default: begin
                state_n = ST_WAIT;
                timer_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ws2812_pattern_gen.sv
// tb_ws2812_pattern_gen
//   Directed bench for ws2812_pattern_gen (NUM_LEDS=5, FRAME_TICKS=4).
//   Expected LED writes are queued when a frame's inputs are driven and are
//   popped by a negedge monitor whenever the DUT asserts write.

module tb_ws2812_pattern_gen;

    localparam int NUM_LEDS    = 5;
    localparam int LED_ADDR_W  = 8;
    localparam int FRAME_TICKS = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  enable = 1'b0;
    logic [1:0]            mode = 2'd0;
    logic [7:0]            level = 8'h00;
    logic [23:0]           rgb_data;
    logic [LED_ADDR_W-1:0] led_num;
    logic                  write;
    logic                  frame_done;
    logic [7:0]            frame_count;

    ws2812_pattern_gen #(
        .NUM_LEDS   (NUM_LEDS),
        .LED_ADDR_W (LED_ADDR_W),
        .FRAME_TICKS(FRAME_TICKS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .level      (level),
        .rgb_data   (rgb_data),
        .led_num    (led_num),
        .write      (write),
        .frame_done (frame_done),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  led;
        logic [23:0] rgb;
    } exp_t;

    exp_t exp_q[$];
    int   rise_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   model_fc = 0;
    int   model_chase = 0;
    logic prev_write = 1'b0;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    // Every comparison funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [23:0] pal(input int k, input logic [7:0] lv);
        case (k % 4)
            0:       return {lv, 8'h00, 8'h00};
            1:       return {8'h00, lv, 8'h00};
            2:       return {8'h00, 8'h00, lv};
            default: return {lv, lv, lv};
        endcase
    endfunction

    // Queue the five writes of the next frame and advance the frame model.
    task automatic push_frame(input int m, input logic [7:0] lv);
        exp_t e;
        for (int i = 0; i < NUM_LEDS; i++) begin
            e.led = 8'(i);
            case (m)
                0:       e.rgb = pal(model_fc, lv);
                1:       e.rgb = (i == model_chase) ? pal(3, lv) : 24'h0;
                2:       e.rgb = pal(i + model_fc, lv);
                default: e.rgb = 24'h0;
            endcase
            exp_q.push_back(e);
        end
        model_fc    = (model_fc + 1) % 256;
        model_chase = (model_chase + 1) % NUM_LEDS;
    endtask

    // Scoreboard monitor: every write cycle must match the head of the queue.
    always @(negedge clk) begin
        if (write) begin
            if (!prev_write) rise_q.push_back(cyc);
            checkOutput("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                checkOutput("led_num", 32'(led_num), 32'(mon_e.led));
                checkOutput("rgb_data", 32'(rgb_data), 32'(mon_e.rgb));
            end
        end
        prev_write <= write;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] m, input logic [7:0] lv);
        enable = en;
        mode   = m;
        level  = lv;
    endtask

    task automatic wait_frame_done(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (frame_done) found = 1'b1;
        end
        checkOutput(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_led(input int idx, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (write && led_num == 8'(idx)) found = 1'b1;
        end
        checkOutput(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int wr_seen;

        $display("[TB] start");
        applyStimulus(1'b0, 2'd0, 8'h00);
        reset = 1'b1;
        repeat (3) step();

        checkOutput("rst_write", 32'(write), 32'd0);
        checkOutput("rst_led_num", 32'(led_num), 32'd0);
        checkOutput("rst_rgb_data", 32'(rgb_data), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_frame_count", 32'(frame_count), 32'd0);

        // First frame: SOLID, level 0x10; release reset (this is cycle 0).
        applyStimulus(1'b1, 2'd0, 8'h10);
        push_frame(0, 8'h10);
        reset = 1'b0;
        repeat (3) step();
        checkOutput("first_write_c3", 32'(write), 32'd0);
        step();
        checkOutput("first_write_c4", 32'(write), 32'd1);
        checkOutput("first_led_c4", 32'(led_num), 32'd0);
        repeat (5) step();
        checkOutput("done_c9", 32'(frame_done), 32'd1);
        checkOutput("write_c9", 32'(write), 32'd0);
        checkOutput("count_c9", 32'(frame_count), 32'd1);
        step();
        checkOutput("done_c10", 32'(frame_done), 32'd0);

        // Four more SOLID frames cycle through the palette.
        for (int f = 0; f < 4; f++) push_frame(0, 8'h10);
        for (int f = 0; f < 4; f++) wait_frame_done("solid_done");
        checkOutput("solid_count", 32'(frame_count), 32'd5);
        checkOutput("solid_rises", 32'(rise_q.size()), 32'd5);
        for (int i = 0; i + 1 < rise_q.size(); i++)
            checkOutput("solid_spacing", 32'(rise_q[i+1] - rise_q[i]), 32'd10);

        // CHASE at full level: lit LED walks 0,1,2,3,4,0,1,2.
        applyStimulus(1'b1, 2'd1, 8'hFF);
        for (int f = 0; f < 8; f++) push_frame(1, 8'hFF);
        for (int f = 0; f < 8; f++) wait_frame_done("chase_done");
        checkOutput("chase_count", 32'(frame_count), 32'd13);

        // GRADIENT with frame_count[1:0]=1; switch to OFF mid-frame.
        applyStimulus(1'b1, 2'd2, 8'h33);
        push_frame(2, 8'h33);
        wait_led(2, "grad_led2");
        applyStimulus(1'b1, 2'd3, 8'h33);
        push_frame(3, 8'h33);
        wait_frame_done("grad_done");
        wait_frame_done("off_done");
        checkOutput("off_count", 32'(frame_count), 32'd15);

        // level = 0 gives all-zero data.
        applyStimulus(1'b1, 2'd0, 8'h00);
        push_frame(0, 8'h00);
        wait_frame_done("level0_done");

        // Drop enable mid-frame: frame still completes, then idle.
        applyStimulus(1'b1, 2'd0, 8'h20);
        push_frame(0, 8'h20);
        wait_led(2, "en_led2");
        enable = 1'b0;
        wait_frame_done("en_drop_done");
        checkOutput("en_drop_count", 32'(frame_count), 32'd17);
        wr_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (write) wr_seen++;
        end
        checkOutput("idle_writes", 32'(wr_seen), 32'd0);

        // Re-raise enable: write rises exactly 4 cycles later.
        push_frame(0, 8'h20);
        applyStimulus(1'b1, 2'd0, 8'h20);
        repeat (3) step();
        checkOutput("reen_c3_write", 32'(write), 32'd0);
        step();
        checkOutput("reen_c4_write", 32'(write), 32'd1);
        checkOutput("reen_c4_led", 32'(led_num), 32'd0);

        // Reset mid-frame at led_num=3.
        wait_led(3, "rst_led3");
        reset = 1'b1;
        step();
        checkOutput("midrst_write", 32'(write), 32'd0);
        checkOutput("midrst_count", 32'(frame_count), 32'd0);
        checkOutput("midrst_done", 32'(frame_done), 32'd0);
        exp_q.delete();
        model_fc    = 0;
        model_chase = 0;

        applyStimulus(1'b1, 2'd0, 8'h10);
        push_frame(0, 8'h10);
        reset = 1'b0;
        repeat (3) step();
        checkOutput("post_rst_c3_write", 32'(write), 32'd0);
        step();
        checkOutput("post_rst_c4_write", 32'(write), 32'd1);
        checkOutput("post_rst_c4_led", 32'(led_num), 32'd0);
        wait_frame_done("post_rst_done");
        checkOutput("post_rst_count", 32'(frame_count), 32'd1);

        enable = 1'b0;
        repeat (12) step();
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
